// File: rtl/rega_timer_ctrl.sv
// Irrigation countdown sequencer: captures an MM:SS BCD preset, counts it down
// on the 1 Hz tick while the valve is open, and handles abort and error exits.
module rega_timer_ctrl #(
  parameter logic [3:0] DS_MAX  = 4'd5,
  parameter logic [3:0] DIG_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       M,
  input  logic       Error,
  input  logic [3:0] preset_dm,
  input  logic [3:0] preset_um,
  input  logic [3:0] preset_ds,
  input  logic [3:0] preset_us,
  output logic [3:0] cnt_dm,
  output logic [3:0] cnt_um,
  output logic [3:0] cnt_ds,
  output logic [3:0] cnt_us,
  output logic       valve,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t     curState;
  logic [3:0] dm, um, ds, us;
  logic [3:0] decDm, decUm, decDs, decUs;
  logic [3:0] ldDm, ldUm, ldDs, ldUs;
  logic       atOneOrLess;
  logic       loadIsZero;

  // Clamp an out-of-range preset digit to its largest legal value
  function automatic logic [3:0] satDigit(input logic [3:0] d, input logic [3:0] maxV);
    return (d > maxV) ? maxV : d;
  endfunction

  // Saturated preset digits, so the counter always starts in legal BCD
  always_comb begin
    ldDm = satDigit(preset_dm, DIG_MAX);
    ldUm = satDigit(preset_um, DIG_MAX);
    ldDs = satDigit(preset_ds, DS_MAX);
    ldUs = satDigit(preset_us, DIG_MAX);
    loadIsZero = (ldDm == 4'd0) && (ldUm == 4'd0) && (ldDs == 4'd0) && (ldUs == 4'd0);
  end

  // One-second BCD decrement with borrow ripple us -> ds -> um -> dm
  always_comb begin
    decUs = us - 4'd1;
    decDs = ds;
    decUm = um;
    decDm = dm;
    if (us == 4'd0) begin
      decUs = DIG_MAX;
      if (ds == 4'd0) begin
        decDs = DS_MAX;
        if (um == 4'd0) begin
          decUm = DIG_MAX;
          decDm = dm - 4'd1;
        end else begin
          decUm = um - 4'd1;
        end
      end else begin
        decDs = ds - 4'd1;
      end
    end
    // 00:00 is included so a zero count can never wrap to 99:59
    atOneOrLess = (dm == 4'd0) && (um == 4'd0) && (ds == 4'd0) && (us <= 4'd1);
  end

  // Sequencer: state, count and registered valve/done/fault (Error beats M beats start/tick)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState <= IDLE;
      dm       <= 4'd0;
      um       <= 4'd0;
      ds       <= 4'd0;
      us       <= 4'd0;
      valve    <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      valve <= 1'b0;
      if (Error) begin
        curState <= FAULT;
        fault    <= 1'b1;
        {dm, um, ds, us} <= 16'h0000;
      end else begin
        case (curState)
          IDLE: begin
            {dm, um, ds, us} <= 16'h0000;
            if (start && M) curState <= LOAD;
          end
          LOAD: begin
            if (!M) begin
              curState <= IDLE;
              {dm, um, ds, us} <= 16'h0000;
            end else begin
              {dm, um, ds, us} <= {ldDm, ldUm, ldDs, ldUs};
              if (loadIsZero) begin
                curState <= DONE;
                done     <= 1'b1;
              end else begin
                curState <= RUN;
                valve    <= 1'b1;
              end
            end
          end
          RUN: begin
            if (!M) begin
              curState <= IDLE;
              {dm, um, ds, us} <= 16'h0000;
            end else if (tick && atOneOrLess) begin
              curState <= DONE;
              done     <= 1'b1;
              {dm, um, ds, us} <= 16'h0000;
            end else begin
              valve <= 1'b1;
              if (tick) {dm, um, ds, us} <= {decDm, decUm, decDs, decUs};
            end
          end
          DONE: begin
            curState <= IDLE;
            {dm, um, ds, us} <= 16'h0000;
          end
          FAULT: begin
            curState <= IDLE;
            {dm, um, ds, us} <= 16'h0000;
          end
          default: begin
            curState <= IDLE;
            {dm, um, ds, us} <= 16'h0000;
          end
        endcase
      end
    end
  end

  // busy follows the registered state directly
  assign busy   = (curState == LOAD) || (curState == RUN);
  assign state  = curState;
  assign cnt_dm = dm;
  assign cnt_um = um;
  assign cnt_ds = ds;
  assign cnt_us = us;

endmodule
